// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one bitwise logic unit (AND/OR/NAND/NOR/NOT/XOR/XNOR) among NUM_REQ
// requesters. A round-robin arbiter grants one request at a time. The operation
// is computed in a registered stage and returned with the winner's ID over a
// valid/ready response channel.
//
// Flow: IDLE (grant + latch) -> EXEC (compute + register) -> RESP (hold until
// taken). Minimum issue interval is 3 cycles.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    operand/result width
//   ID_W     response ID width, $clog2(NUM_REQ)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req_valid   per-requester request valid
//   req_ready   per-requester accept (one-hot or zero, combinational in IDLE)
//   req_op      3-bit opcode per requester, requester i at [3i+2:3i]
//   req_a/b     WIDTH-bit operands per requester
//   resp_valid  result available (high in RESP)
//   resp_ready  consumer accepts result
//   resp_id     index of the requester owning the result
//   resp_data   result
//   resp_err    reserved opcode (7) was issued
//   busy        state is not IDLE
//   gnt_cnt     saturating count of grants (only with LOGIC_ARB_GNT_CNT_EN)
//
// Optional feature: define LOGIC_ARB_GNT_CNT_EN to add the gnt_cnt output.
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [3*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     resp_err,
    output logic                     busy
`ifdef LOGIC_ARB_GNT_CNT_EN
    ,
    output logic [15:0]              gnt_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_rr_ptr;

    // Latched transaction.
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [ID_W-1:0]    r_id;

    // Registered response.
    logic [WIDTH-1:0]   r_resp_data;
    logic               r_resp_err;
    logic [ID_W-1:0]    r_resp_id;

    // Arbitration.
    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic [ID_W-1:0]    w_idx;
    logic [ID_W-1:0]    w_winner_nxt;
    logic               w_accept;

    // Gate result.
    logic [WIDTH-1:0]   w_gate_data;
    logic               w_gate_err;

    // Per-requester views of the flattened request buses.
    logic [2:0]         w_op_arr [NUM_REQ];
    logic [WIDTH-1:0]   w_a_arr  [NUM_REQ];
    logic [WIDTH-1:0]   w_b_arr  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_op_arr[gi] = req_op[3*gi +: 3];
        assign w_a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
        assign w_b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
    end

    // Round-robin search starting at r_rr_ptr; the first valid hit wins.
    // NOTE: combinational blocks use blocking '=' so later statements see the
    // updated value (w_found gates every later candidate in the loop).
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Pointer moves to the requester just after the winner, wrapping at NUM_REQ
    // (which need not be a power of two).
    assign w_winner_nxt = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);

    // Next-state and handshake decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        w_accept     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    req_ready[w_winner] = 1'b1;
                    w_accept            = 1'b1;
                    w_state_next        = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Bitwise logic unit on the latched operands.
    always_comb begin
        w_gate_data = '0;
        w_gate_err  = 1'b0;
        unique case (r_op)
            3'd0:    w_gate_data = r_a & r_b;
            3'd1:    w_gate_data = r_a | r_b;
            3'd2:    w_gate_data = ~(r_a & r_b);
            3'd3:    w_gate_data = ~(r_a | r_b);
            3'd4:    w_gate_data = ~r_a;
            3'd5:    w_gate_data = r_a ^ r_b;
            3'd6:    w_gate_data = ~(r_a ^ r_b);
            default: w_gate_err  = 1'b1;
        endcase
    end

    // State, pointer, transaction and response registers.
    // NOTE: sequential blocks use non-blocking '<=' so all registers update
    // from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
            r_resp_id   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_op     <= w_op_arr[w_winner];
                r_a      <= w_a_arr[w_winner];
                r_b      <= w_b_arr[w_winner];
                r_id     <= w_winner;
                r_rr_ptr <= w_winner_nxt;
            end
            if (r_state == S_EXEC) begin
                r_resp_data <= w_gate_data;
                r_resp_err  <= w_gate_err;
                r_resp_id   <= r_id;
            end
        end
    end

    assign resp_valid = (r_state == S_RESP);
    assign busy       = (r_state != S_IDLE);
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign resp_id    = r_resp_id;

`ifdef LOGIC_ARB_GNT_CNT_EN
    logic [15:0] r_gnt_cnt;

    // Saturating grant counter; holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gnt_cnt <= '0;
        end else if (w_accept && (r_gnt_cnt != 16'hFFFF)) begin
            r_gnt_cnt <= r_gnt_cnt + 16'd1;
        end
    end

    assign gnt_cnt = r_gnt_cnt;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Directed self-checking bench for logic_unit_arbiter (NUM_REQ=4, WIDTH=8).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int ID_W    = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [3*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_data;
    logic                     resp_err;
    logic                     busy;
`ifdef LOGIC_ARB_GNT_CNT_EN
    logic [15:0]              gnt_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic_unit_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
`ifdef LOGIC_ARB_GNT_CNT_EN
        ,
        .gnt_cnt    (gnt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the stimulus is fixed-length, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive_req(input int idx, input logic [2:0] op,
                             input logic [7:0] a, input logic [7:0] b);
        req_op[3*idx +: 3]         = op;
        req_a[WIDTH*idx +: WIDTH]  = a;
        req_b[WIDTH*idx +: WIDTH]  = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Single isolated transaction on requester idx with resp_ready=1.
    // Entered 1 unit after an edge with the DUT in IDLE; leaves it the same way.
    task automatic do_op(input string tag, input int idx, input logic [2:0] op,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_data, input logic exp_err);
        drive_req(idx, op, a, b);
        req_valid = 4'(1 << idx);
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check({tag, "_exec_valid"}, 32'(resp_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_data"},  32'(resp_data),  32'(exp_data));
        check({tag, "_id"},    32'(resp_id),    32'(idx));
        check({tag, "_err"},   32'(resp_err),   32'(exp_err));
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [8] = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'h5A, 8'hAA, 8'h55, 8'h00};
    int         rr_ids    [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
    logic [7:0] rr_data   [4] = '{8'h30, 8'h81, 8'hAA, 8'hF0};

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;

        // Reset then idle.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_resp_valid", 32'(resp_valid), 32'd0);
            check("idle_busy",       32'(busy),       32'd0);
            check("idle_req_ready",  32'(req_ready),  32'd0);
        end
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_id",   32'(resp_id),   32'd0);
        check("rst_resp_err",  32'(resp_err),  32'd0);
`ifdef LOGIC_ARB_GNT_CNT_EN
        check("rst_gnt_cnt", 32'(gnt_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;

        // Single op: AND F0 & 3C = 30.
        do_op("single", 0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
        @(negedge clk);
        check("single_done_valid", 32'(resp_valid), 32'd0);
        check("single_done_busy",  32'(busy),       32'd0);
        @(posedge clk);
        #1;

        // Opcode sweep on requester 2.
        for (int op = 0; op < 8; op++) begin
            do_op($sformatf("sweep_op%0d", op), 2, 3'(op), 8'hA5, 8'h0F,
                  sweep_exp[op], (op == 7));
        end

        // Round-robin from rr_ptr=0 with all requesters valid.
        do_reset();
        drive_req(0, 3'd0, 8'hF0, 8'h3C);
        drive_req(1, 3'd1, 8'h01, 8'h80);
        drive_req(2, 3'd5, 8'hA5, 8'h0F);
        drive_req(3, 3'd3, 8'h00, 8'h0F);
        req_valid = 4'hF;
        for (int g = 0; g < 10; g++) begin
            @(negedge clk);
            check($sformatf("rr%0d_ready", g), 32'(req_ready), 32'(1 << rr_ids[g]));
            @(negedge clk);
            check($sformatf("rr%0d_exec_ready", g), 32'(req_ready), 32'd0);
            @(negedge clk);
            check($sformatf("rr%0d_id", g),   32'(resp_id),   32'(rr_ids[g]));
            check($sformatf("rr%0d_data", g), 32'(resp_data), 32'(rr_data[rr_ids[g]]));
            if (g == 5) req_valid = 4'b1101;
            if (g == 9) req_valid = 4'b0000;
        end
        @(posedge clk);
        #1;

        // Backpressure: requester 3 (rr_ptr=3), XNOR 0F,0F = FF; req0 waits.
        resp_ready = 1'b0;
        drive_req(3, 3'd6, 8'h0F, 8'h0F);
        req_valid = 4'b1000;
        @(negedge clk);
        check("bp_ready", 32'(req_ready), 32'b1000);
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        @(negedge clk);
        check("bp_exec_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_data",  32'(resp_data),  32'hFF);
            check("bp_id",    32'(resp_id),    32'd3);
            check("bp_ready0", 32'(req_ready), 32'd0);
            check("bp_busy",  32'(busy),       32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        check("bp_release_busy",  32'(busy),       32'd0);
        check("bp_hold_data",     32'(resp_data),  32'hFF);
        check("bp_hold_id",       32'(resp_id),    32'd3);
        check("bp_pending_ready", 32'(req_ready),  32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        check("bp_pending_id",   32'(resp_id),   32'd0);
        check("bp_pending_data", 32'(resp_data), 32'h30);
        @(posedge clk);
        #1;

        // Reset during EXEC: transaction dropped, pointer back to 0.
        drive_req(2, 3'd1, 8'h11, 8'h22);
        req_valid = 4'b0100;
        @(negedge clk);
        check("rmid_ready", 32'(req_ready), 32'b0100);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("rmid_exec_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rmid_no_valid", 32'(resp_valid), 32'd0);
            check("rmid_no_busy",  32'(busy),       32'd0);
        end
`ifdef LOGIC_ARB_GNT_CNT_EN
        check("rmid_gnt_cnt0", 32'(gnt_cnt), 32'd0);
`endif
        @(posedge clk);
        #1;
        drive_req(1, 3'd4, 8'h0F, 8'h00);
        drive_req(3, 3'd0, 8'hFF, 8'hFF);
        req_valid = 4'b1010;
        @(negedge clk);
        check("rmid_grant_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
`ifdef LOGIC_ARB_GNT_CNT_EN
        check("rmid_gnt_cnt1", 32'(gnt_cnt), 32'd1);
`endif
        @(negedge clk);
        check("rmid_resp_valid", 32'(resp_valid), 32'd1);
        check("rmid_resp_id",    32'(resp_id),    32'd1);
        check("rmid_resp_data",  32'(resp_data),  32'hF0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
